// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority encoder.
//   N_SRC : number of interrupt request lines.
//   ID_W  : width of the encoded source ID (clog2(N_SRC)).
//   irq_state_e : handshake FSM states.
package irq_pkg;
  localparam int N_SRC = 32;
  localparam int ID_W  = 5;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PRESENT = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/prio_enc32.sv
// Combinational 32->5 priority encoder. The lowest set index wins.
//   in  : request vector
//   out : index of the lowest set bit (0 when in == 0)
//   any : at least one bit of in is set
module prio_enc32
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] in,
  output logic [ID_W-1:0]  out,
  output logic             any
);

  // Scan from the top down so the last match, which is the lowest index, wins.
  always_comb begin
    out = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (in[i]) out = ID_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/irq_prio_enc.sv
// Interrupt priority encoder for the CP0 path.
// Rising edges on irq_in are captured into a pending register. The
// highest-priority unmasked pending source (lowest index) is presented over a
// valid/ack handshake. It is then held in service until eoi. Nesting is not
// supported.
//   clk, rst    : clock, asynchronous active-high reset
//   irq_in      : level request lines, synchronous to clk
//   mask_we     : mask write strobe
//   mask_wdata  : new mask; bit=1 enables the source
//   ack         : CPU takes the presented interrupt
//   eoi         : CPU finished servicing the current interrupt
//   irq_valid   : interrupt presented
//   irq_id      : presented source ID
//   mask_q      : current mask register
//   pending_q   : current pending register
//   busy        : a source is in service
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pending_q,
  output logic             busy
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] rise, cand, clr, pending_d;
  logic [ID_W-1:0]  enc_id, id_d;
  logic             enc_any, valid_d, busy_d, take;

  assign rise = irq_in & ~irq_prev;
  assign cand = pending_q & mask_q;

  prio_enc32 u_enc (
    .in  (cand),
    .out (enc_id),
    .any (enc_any)
  );

  // Clear the acknowledged bit. A same-cycle rise on that bit wins, so the
  // edge is not lost.
  assign clr       = take ? (N_SRC'(1) << irq_id) : '0;
  assign pending_d = (pending_q & ~clr) | rise;

  always_comb begin
    state_d = state_q;
    id_d    = irq_id;
    valid_d = irq_valid;
    busy_d  = busy;
    take    = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (enc_any) begin
          id_d    = enc_id;
          valid_d = 1'b1;
          state_d = IRQ_PRESENT;
        end
      end
      // irq_id and irq_valid stay frozen here, whatever mask and pending do.
      IRQ_PRESENT: begin
        if (ack) begin
          take    = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = IRQ_SERVICE;
        end
      end
      IRQ_SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = IRQ_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IRQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_prev  <= irq_in;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      irq_valid <= valid_d;
      irq_id    <= id_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_irq_prio_enc.sv
module tb_irq_prio_enc;
  import irq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] irq_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             ack, eoi;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] mask_q, pending_q;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  logic [ID_W-1:0] exp_q[$];

  irq_prio_enc dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ack(ack), .eoi(eoi), .irq_valid(irq_valid),
    .irq_id(irq_id), .mask_q(mask_q), .pending_q(pending_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new presentation pops the next expected ID.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (irq_valid === 1'b1 && prev_v !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_presentation", 32'(irq_id), 32'hFFFF_FFFF);
        end else begin
          chk("presented_id", 32'(irq_id), 32'(exp_q.pop_front()));
        end
      end
      prev_v = irq_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_mask(input logic [31:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic do_ack_eoi();
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_mask", mask_q, 0);
    chk("rst_pending", pending_q, 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // 1: single source, two-edge latency
    set_mask(32'hFFFF_FFFF);
    chk("t1_mask", mask_q, 32'hFFFF_FFFF);
    exp_q.push_back(5'd7);
    irq_in[7] = 1'b1; tick(); irq_in = '0;
    chk("t1_pending", pending_q, 32'h0000_0080);
    chk("t1_not_yet", 32'(irq_valid), 0);
    tick();
    chk("t1_valid", 32'(irq_valid), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_pend_clr", pending_q, 0);
    chk("t1_valid_drop", 32'(irq_valid), 0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t1_idle", 32'(busy), 0);

    // 2: simultaneous rises, lowest index first
    exp_q.push_back(5'd3); exp_q.push_back(5'd20);
    irq_in[3] = 1'b1; irq_in[20] = 1'b1; tick(); irq_in = '0;
    tick();
    chk("t2_id3", 32'(irq_id), 3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_pending", pending_q, 32'h0010_0000);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_gap", 32'(irq_valid), 0);
    tick();
    chk("t2_id20", 32'(irq_id), 20);
    chk("t2_valid20", 32'(irq_valid), 1);
    do_ack_eoi();

    // 3: masked capture, release on unmask
    set_mask(32'h0);
    irq_in[5] = 1'b1; tick(); irq_in = '0;
    tick(); tick();
    chk("t3_pending", pending_q, 32'h0000_0020);
    chk("t3_masked", 32'(irq_valid), 0);
    exp_q.push_back(5'd5);
    set_mask(32'h0000_0020);
    tick();
    chk("t3_valid", 32'(irq_valid), 1);
    chk("t3_id", 32'(irq_id), 5);
    do_ack_eoi();
    set_mask(32'hFFFF_FFFF);

    // 4: re-rise on the ack cycle is not lost
    exp_q.push_back(5'd9);
    irq_in[9] = 1'b1; tick(); irq_in = '0;
    tick();
    chk("t4_id", 32'(irq_id), 9);
    exp_q.push_back(5'd9);
    ack = 1'b1; irq_in[9] = 1'b1; tick(); ack = 1'b0; irq_in = '0;
    chk("t4_pend_kept", pending_q, 32'h0000_0200);
    chk("t4_busy", 32'(busy), 1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("t4_represent", 32'(irq_valid), 1);
    do_ack_eoi();

    // 5: held level pends once
    exp_q.push_back(5'd2);
    irq_in[2] = 1'b1; ack = 1'b1; eoi = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    irq_in = '0; ack = 1'b0; eoi = 1'b0;
    tick();
    chk("t5_pending", pending_q, 0);
    chk("t5_busy", 32'(busy), 0);

    // boundary: bits 0 and 31
    exp_q.push_back(5'd0); exp_q.push_back(5'd31);
    irq_in[0] = 1'b1; irq_in[31] = 1'b1; tick(); irq_in = '0;
    tick();
    chk("b_id0", 32'(irq_id), 0);
    do_ack_eoi();
    tick();
    chk("b_id31", 32'(irq_id), 31);

    // 6: async reset during service
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(irq_valid), 0);
    chk("t6_mask", mask_q, 0);
    tick();
    rst = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("t6_eoi_busy", 32'(busy), 0);
    chk("t6_eoi_valid", 32'(irq_valid), 0);
    chk("t6_eoi_pending", pending_q, 0);

    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
